// File: rtl/model_coeff_store.sv
// model_coeff_store: coefficient store for a Levinson-Durbin model solver.
// Holds ORDER_MAX+1 single-precision coefficients. Entry 0 is fixed at 1.0;
// all other entries are updated by writebacks or reflection-coefficient commits.
// There are two registered model read ports plus an independent dump port.
// Optional feature macro: MODEL_STORE_BYPASS_EN. When it is defined, a read of
// an entry written in the same cycle returns the new value instead of the old.
//
// Handshake: iValid qualifies iTarget*/iNewModel* for exactly the cycle it is
// high, and there is no back-pressure. iCommit is a one-cycle request. A commit
// that arrives with a writeback is parked (oBusy high) until the first cycle
// in which iValid is low, so the writeback always lands before the commit.
module model_coeff_store #(
  parameter int DATA_W    = 32,
  parameter int ORDER_MAX = 12
) (
  input  logic              iClock,
  input  logic              iReset,
  input  logic              iEnable,
  input  logic              iClear,
  input  logic [3:0]        iSel1,
  input  logic [3:0]        iSel2,
  output logic [DATA_W-1:0] oModel1,
  output logic [DATA_W-1:0] oModel2,
  input  logic [3:0]        iTarget1,
  input  logic [3:0]        iTarget2,
  input  logic [DATA_W-1:0] iNewModel1,
  input  logic [DATA_W-1:0] iNewModel2,
  input  logic              iOnlyOne,
  input  logic              iValid,
  input  logic [3:0]        iM,
  input  logic [DATA_W-1:0] iKm,
  input  logic              iCommit,
  input  logic [3:0]        iRdAddr,
  output logic [DATA_W-1:0] oRdData,
  output logic              oDone,
  output logic              oCollide,
  output logic              oBusy,
  output logic [1:0]        oState
);

  localparam int N = ORDER_MAX + 1;
  localparam logic [DATA_W-1:0] ONE = DATA_W'(32'h3f800000);

  typedef enum logic [1:0] {
    S_IDLE        = 2'd0,
    S_ARMED       = 2'd1,
    S_COMMIT_WAIT = 2'd2,
    S_DONE        = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [DATA_W-1:0] r_mem     [N];
  logic [DATA_W-1:0] w_mem_nxt [N];
  logic [DATA_W-1:0] w_rd_src  [N];
  logic [3:0]        r_pend_m;
  logic [DATA_W-1:0] r_pend_km;
  logic [DATA_W-1:0] r_model1;
  logic [DATA_W-1:0] r_model2;
  logic [DATA_W-1:0] r_rd_data;
  logic              r_collide;
  logic              w_wr1;
  logic              w_wr2;
  logic              w_collide;
  logic              w_cwr;
  logic              w_latch;
  logic [3:0]        w_caddr;
  logic [DATA_W-1:0] w_cdata;
  logic [DATA_W-1:0] w_rd1;
  logic [DATA_W-1:0] w_rd2;
  logic [DATA_W-1:0] w_rdd;

  // When the two targets of a dual writeback collide, Target1 wins and
  // Target2 is suppressed.
  assign w_wr1     = iEnable & iValid & ~iClear;
  assign w_wr2     = w_wr1 & ~iOnlyOne & (iTarget2 != iTarget1);
  assign w_collide = w_wr1 & ~iOnlyOne & (iTarget2 == iTarget1);

  // State register.
  always_ff @(posedge iClock or posedge iReset) begin
    if (iReset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic and commit-write decode. A clear overrides everything.
  always_comb begin
    w_state_nxt = r_state;
    w_cwr       = 1'b0;
    w_latch     = 1'b0;
    w_caddr     = iM;
    w_cdata     = iKm;
    if (iClear) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (iEnable) w_state_nxt = S_ARMED;
        end
        S_ARMED: begin
          if (!iEnable) begin
            w_state_nxt = S_IDLE;
          end else if (iCommit) begin
            if (iValid) begin
              w_latch     = 1'b1;
              w_state_nxt = S_COMMIT_WAIT;
            end else begin
              w_cwr       = 1'b1;
              w_state_nxt = S_DONE;
            end
          end
        end
        S_COMMIT_WAIT: begin
          // Completes even if iEnable has dropped.
          if (!iValid) begin
            w_cwr       = 1'b1;
            w_caddr     = r_pend_m;
            w_cdata     = r_pend_km;
            w_state_nxt = S_DONE;
          end
        end
        S_DONE: begin
          w_state_nxt = iEnable ? S_ARMED : S_IDLE;
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Parked commit. It is dropped on a clear.
  always_ff @(posedge iClock or posedge iReset) begin
    if (iReset) begin
      r_pend_m  <= '0;
      r_pend_km <= '0;
    end else if (iClear) begin
      r_pend_m  <= '0;
      r_pend_km <= '0;
    end else if (w_latch) begin
      r_pend_m  <= iM;
      r_pend_km <= iKm;
    end
  end

  // Next contents of every entry. Entry 0 is only ever set by a clear.
  // Addresses beyond ORDER_MAX match no entry, so those writes are dropped.
  always_comb begin
    for (int k = 0; k < N; k++) begin
      w_mem_nxt[k] = r_mem[k];
      if (iClear) begin
        w_mem_nxt[k] = (k == 0) ? ONE : '0;
      end else if (k != 0) begin
        if (w_wr1 && (iTarget1 == 4'(k)))      w_mem_nxt[k] = iNewModel1;
        else if (w_wr2 && (iTarget2 == 4'(k))) w_mem_nxt[k] = iNewModel2;
        else if (w_cwr && (w_caddr == 4'(k)))  w_mem_nxt[k] = w_cdata;
      end
    end
  end

  // Coefficient storage. Reset leaves the store in its cleared contents.
  always_ff @(posedge iClock or posedge iReset) begin
    if (iReset) begin
      for (int k = 0; k < N; k++) r_mem[k] <= (k == 0) ? ONE : '0;
    end else begin
      for (int k = 0; k < N; k++) r_mem[k] <= w_mem_nxt[k];
    end
  end

  // Read source: current contents, or this cycle's write results when bypassed.
  always_comb begin
    for (int k = 0; k < N; k++) begin
`ifdef MODEL_STORE_BYPASS_EN
      w_rd_src[k] = w_mem_nxt[k];
`else
      w_rd_src[k] = r_mem[k];
`endif
    end
  end

  // Read address decode. Out-of-range addresses read as zero.
  always_comb begin
    w_rd1 = '0;
    w_rd2 = '0;
    w_rdd = '0;
    for (int k = 0; k < N; k++) begin
      if (iSel1 == 4'(k))   w_rd1 = w_rd_src[k];
      if (iSel2 == 4'(k))   w_rd2 = w_rd_src[k];
      if (iRdAddr == 4'(k)) w_rdd = w_rd_src[k];
    end
  end

  // Registered read ports and the collision pulse. The model ports follow
  // iEnable, and the dump port is free-running.
  always_ff @(posedge iClock or posedge iReset) begin
    if (iReset) begin
      r_model1  <= '0;
      r_model2  <= '0;
      r_rd_data <= '0;
      r_collide <= 1'b0;
    end else begin
      if (iEnable) begin
        r_model1 <= w_rd1;
        r_model2 <= w_rd2;
      end
      r_rd_data <= w_rdd;
      r_collide <= w_collide;
    end
  end

  assign oModel1  = r_model1;
  assign oModel2  = r_model2;
  assign oRdData  = r_rd_data;
  assign oCollide = r_collide;
  assign oDone    = (r_state == S_DONE);
  assign oBusy    = (r_state == S_COMMIT_WAIT) || (r_state == S_DONE);
  assign oState   = r_state;

endmodule

// File: doc/model_coeff_store.md
MODEL_COEFF_STORE -- requirements
Module: model_coeff_store

Interface
REQ-001 Parameter DATA_W, default 32, width of one IEEE-754 single-precision coefficient.
REQ-002 Parameter ORDER_MAX, default 12, highest coefficient index; the store holds ORDER_MAX+1 entries.
REQ-003 iClock  in  1  sole clock; all state updates on its rising edge.
REQ-004 iReset  in  1  asynchronous, active-high reset.
REQ-005 iEnable  in  1  reads, writebacks and commits are accepted only while high.
REQ-006 iClear  in  1  synchronous re-initialisation of the store for a new Levinson-Durbin run.
REQ-007 iSel1, iSel2  in  4 each  read addresses driven by the model selector.
REQ-008 oModel1, oModel2  out  DATA_W each  registered read data for iSel1/iSel2.
REQ-009 iTarget1, iTarget2  in  4 each  writeback addresses.
REQ-010 iNewModel1, iNewModel2  in  DATA_W each  writeback data.
REQ-011 iOnlyOne  in  1  when high, only the Target1/NewModel1 pair is written.
REQ-012 iValid  in  1  qualifies the writeback inputs for one cycle.
REQ-013 iM  in  4, iKm  in  DATA_W  order index and reflection coefficient for the commit.
REQ-014 iCommit  in  1  one-cycle request to write iKm into entry iM.
REQ-015 iRdAddr  in  4, oRdData  out  DATA_W  independent registered dump port.
REQ-016 oDone  out  1, oCollide  out  1, oBusy  out  1  status outputs.

Function
REQ-017 Read latency is exactly one cycle on all three read ports; an address above ORDER_MAX returns 0.
REQ-018 Reads are read-before-write: a read of an entry written in the same cycle returns the old value (overridden by REQ-031).
REQ-019 On iEnable and iValid, entry iTarget1 takes iNewModel1; if iOnlyOne is low, entry iTarget2 also takes iNewModel2.
REQ-020 A writeback to an address above ORDER_MAX is dropped, and entry 0 is never written by a writeback or commit.
REQ-021 If iOnlyOne is low and iTarget1 equals iTarget2, only iNewModel1 is written and oCollide pulses high for one cycle.
REQ-022 The state machine has four states: IDLE, ARMED, COMMIT_WAIT and DONE; IDLE goes to ARMED when iEnable is high.
REQ-023 In ARMED, iCommit with iValid low writes iKm to entry iM in that cycle and the state goes to DONE.
REQ-024 In ARMED, iCommit with iValid high latches iKm and iM and goes to COMMIT_WAIT, so the writeback is applied first.
REQ-025 COMMIT_WAIT writes the latched iKm into the latched iM on the next cycle in which iValid is low, then goes to DONE.
REQ-026 DONE drives oDone high for exactly one cycle and then returns to ARMED if iEnable is high, otherwise to IDLE.
REQ-027 oBusy is high in COMMIT_WAIT and in DONE.
REQ-028 iEnable falling in ARMED returns the state to IDLE; in COMMIT_WAIT the pending commit still completes.
REQ-029 iClear takes priority over all other inputs: entry 0 becomes 32'h3f800000 (1.0), all other entries become 0, the state goes to IDLE and any pending commit is dropped.

Reset
REQ-030 While iReset is asserted:
- the store is in the iClear state;
- the state is IDLE;
- oModel1, oModel2, oRdData, oDone, oCollide and oBusy are all 0.

Configuration
REQ-031 Macro MODEL_STORE_BYPASS_EN:
- when defined, a read of an entry written in the same cycle returns the newly written value (write-to-read forwarding, NewModel1 taking precedence);
- when undefined, REQ-018 holds unchanged.

Verification
REQ-032 Reset, then read all entries via iRdAddr -> entry 0 = 3f800000, entries 1..12 = 0, every status output = 0.
REQ-033 Write entry 1 = bf7f7cee, then iM=2, iKm=3f6be0df, iCommit -> dump shows 3f800000, bf7f7cee, 3f6be0df, zeros; oDone pulses one cycle.
REQ-034 iCommit together with iValid (iTarget1=1, value 3e000000) -> oBusy high; entry 1 updated first, then the commit; oDone one cycle later than in REQ-033.
REQ-035 iValid, iOnlyOne=0, iTarget1=iTarget2=2 with values A and B -> entry 2 = A, oCollide pulses once.
REQ-036 iSel1=3 while writing entry 3 in the same cycle -> oModel1 = old value without MODEL_STORE_BYPASS_EN, new value with it.
REQ-037 iReset asserted in COMMIT_WAIT -> pending commit lost, store back to its reset contents, oBusy 0 immediately.
